// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU: 5-bit opcode encodings and a
//               helper that widens a 33-bit add/sub result to 64 bits.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int unsigned c_OP_W = 5;

    localparam logic [c_OP_W-1:0] c_OP_ADD  = 5'd0;
    localparam logic [c_OP_W-1:0] c_OP_SUB  = 5'd1;
    localparam logic [c_OP_W-1:0] c_OP_MUL  = 5'd2;
    localparam logic [c_OP_W-1:0] c_OP_DIV  = 5'd3;
    localparam logic [c_OP_W-1:0] c_OP_AND  = 5'd4;
    localparam logic [c_OP_W-1:0] c_OP_OR   = 5'd5;
    localparam logic [c_OP_W-1:0] c_OP_SHR  = 5'd6;
    localparam logic [c_OP_W-1:0] c_OP_SHRA = 5'd7;
    localparam logic [c_OP_W-1:0] c_OP_SHL  = 5'd8;
    localparam logic [c_OP_W-1:0] c_OP_ROR  = 5'd9;
    localparam logic [c_OP_W-1:0] c_OP_ROL  = 5'd10;
    localparam logic [c_OP_W-1:0] c_OP_NEG  = 5'd11;
    localparam logic [c_OP_W-1:0] c_OP_NOT  = 5'd12;

    // Widen a 33-bit sum/difference: sign-extend from bit 32 in signed mode,
    // zero-extend otherwise.
    function automatic logic [63:0] f_ext33(input logic [32:0] v, input logic is_signed);
        return is_signed ? {{31{v[32]}}, v} : {31'b0, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_div.sv
`default_nettype none
// ============================================================================
// Module      : alu_div
// Description : Combinational 32-bit signed/unsigned divider.
//               Signed division truncates toward zero; the remainder carries
//               the dividend's sign. Divide by zero yields quotient all-ones
//               and remainder equal to the dividend.
// Ports       : i_dividend  [31:0] dividend
//               i_divisor   [31:0] divisor
//               i_signed           1 = two's complement operands
//               o_quotient  [31:0] quotient
//               o_remainder [31:0] remainder
// Revision    : 1.0 - initial release
// ============================================================================
module alu_div
    import alu_pkg::*;
(
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic        i_signed,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_a_neg    = i_signed & i_dividend[31];
    assign w_b_neg    = i_signed & i_divisor[31];

    // Magnitudes; -2^31 maps onto 32'h80000000, which the unsigned divide
    // handles correctly, so 0x80000000 / -1 naturally returns 0x80000000.
    assign w_a_mag    = w_a_neg ? (32'd0 - i_dividend) : i_dividend;
    assign w_b_mag    = w_b_neg ? (32'd0 - i_divisor)  : i_divisor;

    assign w_div_zero = (i_divisor == 32'd0);
    // Keep the divider datapath away from a zero denominator.
    assign w_den      = w_div_zero ? 32'd1 : w_b_mag;

    assign w_q_mag    = w_a_mag / w_den;
    assign w_r_mag    = w_a_mag % w_den;

    assign w_q        = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    assign o_quotient  = w_div_zero ? 32'hFFFF_FFFF : w_q;
    assign o_remainder = w_div_zero ? i_dividend    : w_r;

endmodule
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_unit
// Description : 32-bit ALU with a registered 64-bit result (1-cycle latency).
//               Operations: ADD SUB MUL DIV AND OR SHR SHRA SHL ROR ROL NEG
//               NOT; unused opcodes return zero.
// Ports       : clock          rising-edge clock
//               clear          synchronous active-low reset
//               input_a [31:0] operand A
//               input_b [31:0] operand B ([4:0] = shift/rotate amount)
//               opcode  [4:0]  operation select
//               unsigned_flag  1 = signed, 0 = unsigned (ADD/SUB/MUL/DIV)
//               ALU_result [63:0] registered result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_unit
    import alu_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    input  logic [4:0]  opcode,
    input  logic        unsigned_flag,
    output logic [63:0] ALU_result
);

    logic [63:0] r_result;

    logic [4:0]  w_shamt;
    logic [5:0]  w_shamt_inv;
    logic [32:0] w_a33;
    logic [32:0] w_b33;
    logic [32:0] w_sum;
    logic [32:0] w_diff;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_mul;
    logic [31:0] w_sra;
    logic [31:0] w_ror;
    logic [31:0] w_rol;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_next;

    assign w_shamt     = input_b[4:0];
    assign w_shamt_inv = 6'd32 - {1'b0, w_shamt};

    // One extra bit holds the true sign (signed) or carry/borrow (unsigned).
    assign w_a33  = {unsigned_flag & input_a[31], input_a};
    assign w_b33  = {unsigned_flag & input_b[31], input_b};
    assign w_sum  = w_a33 + w_b33;
    assign w_diff = w_a33 - w_b33;

    // The low 64 bits of a 64x64 product of properly extended operands are
    // the exact 32x32 product in both signed and unsigned modes.
    assign w_a64  = unsigned_flag ? {{32{input_a[31]}}, input_a} : {32'b0, input_a};
    assign w_b64  = unsigned_flag ? {{32{input_b[31]}}, input_b} : {32'b0, input_b};
    assign w_mul  = w_a64 * w_b64;

    assign w_sra  = $signed(input_a) >>> w_shamt;
    // A shift by 32 yields zero, so a zero amount returns input_a unchanged.
    assign w_ror  = (input_a >> w_shamt) | (input_a << w_shamt_inv);
    assign w_rol  = (input_a << w_shamt) | (input_a >> w_shamt_inv);

    alu_div u_div (
        .i_dividend  (input_a),
        .i_divisor   (input_b),
        .i_signed    (unsigned_flag),
        .o_quotient  (w_quot),
        .o_remainder (w_rem)
    );

    always_comb begin
        w_next = 64'h0;
        case (opcode)
            c_OP_ADD:  w_next = f_ext33(w_sum,  unsigned_flag);
            c_OP_SUB:  w_next = f_ext33(w_diff, unsigned_flag);
            c_OP_MUL:  w_next = w_mul;
            c_OP_DIV:  w_next = {w_rem, w_quot};
            c_OP_AND:  w_next = {32'b0, input_a & input_b};
            c_OP_OR:   w_next = {32'b0, input_a | input_b};
            c_OP_SHR:  w_next = {32'b0, input_a >> w_shamt};
            c_OP_SHRA: w_next = {32'b0, w_sra};
            c_OP_SHL:  w_next = {32'b0, input_a << w_shamt};
            c_OP_ROR:  w_next = {32'b0, w_ror};
            c_OP_ROL:  w_next = {32'b0, w_rol};
            c_OP_NEG:  w_next = {32'b0, 32'd0 - input_a};
            c_OP_NOT:  w_next = {32'b0, ~input_a};
            default:   w_next = 64'h0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_result <= 64'h0;
        end else begin
            r_result <= w_next;
        end
    end

    assign ALU_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_unit
// Description : Self-checking bench for alu_unit: a table of directed vectors
//               with hand-computed results, plus reset and input-hold
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_unit;
    import alu_pkg::*;

    logic        clock;
    logic        clear;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [4:0]  opcode;
    logic        unsigned_flag;
    logic [63:0] ALU_result;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic        sf;
        logic [63:0] exp;
    } vec_t;

    localparam int c_NVEC = 36;
    vec_t vecs [c_NVEC];

    alu_unit dut (
        .clock         (clock),
        .clear         (clear),
        .input_a       (input_a),
        .input_b       (input_b),
        .opcode        (opcode),
        .unsigned_flag (unsigned_flag),
        .ALU_result    (ALU_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic sf);
        input_a       = a;
        input_b       = b;
        opcode        = op;
        unsigned_flag = sf;
    endtask

    task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic sf, input logic [63:0] exp);
        vecs[i].a   = a;
        vecs[i].b   = b;
        vecs[i].op  = op;
        vecs[i].sf  = sf;
        vecs[i].exp = exp;
    endtask

    initial begin
        set_vec( 0, 32'd5,         32'd7,         c_OP_ADD,  1'b0, 64'h00000000_0000000C);
        set_vec( 1, 32'hFFFFFFFF,  32'd1,         c_OP_ADD,  1'b0, 64'h00000001_00000000);
        set_vec( 2, 32'hFFFFFFFF,  32'd1,         c_OP_ADD,  1'b1, 64'h00000000_00000000);
        set_vec( 3, 32'h7FFFFFFF,  32'd1,         c_OP_ADD,  1'b1, 64'h00000000_80000000);
        set_vec( 4, 32'd3,         32'd5,         c_OP_SUB,  1'b0, 64'h00000001_FFFFFFFE);
        set_vec( 5, 32'd3,         32'd5,         c_OP_SUB,  1'b1, 64'hFFFFFFFF_FFFFFFFE);
        set_vec( 6, 32'h80000000,  32'd1,         c_OP_SUB,  1'b1, 64'hFFFFFFFF_7FFFFFFF);
        set_vec( 7, 32'hFFFFFFFE,  32'd3,         c_OP_MUL,  1'b1, 64'hFFFFFFFF_FFFFFFFA);
        set_vec( 8, 32'hFFFFFFFE,  32'd3,         c_OP_MUL,  1'b0, 64'h00000002_FFFFFFFA);
        set_vec( 9, 32'hFFFFFFF9,  32'd2,         c_OP_DIV,  1'b1, 64'hFFFFFFFF_FFFFFFFD);
        set_vec(10, 32'd5,         32'd0,         c_OP_DIV,  1'b0, 64'h00000005_FFFFFFFF);
        set_vec(11, 32'd5,         32'd0,         c_OP_DIV,  1'b1, 64'h00000005_FFFFFFFF);
        set_vec(12, 32'h80000000,  32'hFFFFFFFF,  c_OP_DIV,  1'b1, 64'h00000000_80000000);
        set_vec(13, 32'h80000000,  32'hFFFFFFFF,  c_OP_DIV,  1'b0, 64'h80000000_00000000);
        set_vec(14, 32'd7,         32'hFFFFFFFE,  c_OP_DIV,  1'b1, 64'h00000001_FFFFFFFD);
        set_vec(15, 32'd100,       32'd7,         c_OP_DIV,  1'b0, 64'h00000002_0000000E);
        set_vec(16, 32'hF0F0F0F0,  32'hFF00FF00,  c_OP_AND,  1'b1, 64'h00000000_F000F000);
        set_vec(17, 32'h0F0F0000,  32'h000000F0,  c_OP_OR,   1'b0, 64'h00000000_0F0F00F0);
        set_vec(18, 32'h80000000,  32'hFFFFFFE4,  c_OP_SHR,  1'b1, 64'h00000000_08000000);
        set_vec(19, 32'h80000000,  32'd4,         c_OP_SHRA, 1'b0, 64'h00000000_F8000000);
        set_vec(20, 32'h40000000,  32'd4,         c_OP_SHRA, 1'b1, 64'h00000000_04000000);
        set_vec(21, 32'h00000001,  32'd31,        c_OP_SHL,  1'b0, 64'h00000000_80000000);
        set_vec(22, 32'h12345678,  32'd0,         c_OP_SHL,  1'b0, 64'h00000000_12345678);
        set_vec(23, 32'h00000001,  32'd1,         c_OP_ROR,  1'b0, 64'h00000000_80000000);
        set_vec(24, 32'h80000001,  32'd1,         c_OP_ROL,  1'b0, 64'h00000000_00000003);
        set_vec(25, 32'h12345678,  32'd0,         c_OP_ROL,  1'b1, 64'h00000000_12345678);
        set_vec(26, 32'h12345678,  32'd8,         c_OP_ROR,  1'b1, 64'h00000000_78123456);
        set_vec(27, 32'd1,         32'd0,         c_OP_NEG,  1'b1, 64'h00000000_FFFFFFFF);
        set_vec(28, 32'd1,         32'd0,         c_OP_NEG,  1'b0, 64'h00000000_FFFFFFFF);
        set_vec(29, 32'd0,         32'd0,         c_OP_NOT,  1'b0, 64'h00000000_FFFFFFFF);
        set_vec(30, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd20,     1'b1, 64'h00000000_00000000);
        set_vec(31, 32'h12345678,  32'h9ABCDEF0,  5'd13,     1'b0, 64'h00000000_00000000);
        set_vec(32, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd31,     1'b0, 64'h00000000_00000000);
        set_vec(33, 32'h00000000,  32'd0,         c_OP_SHR,  1'b0, 64'h00000000_00000000);
        set_vec(34, 32'hA5A5A5A5,  32'd0,         c_OP_SHRA, 1'b1, 64'h00000000_A5A5A5A5);
        set_vec(35, 32'h80000000,  32'd31,        c_OP_SHRA, 1'b0, 64'h00000000_FFFFFFFF);

        // Reset state
        clear = 1'b0;
        drive(32'd2, 32'd3, c_OP_MUL, 1'b0);
        @(posedge clock); #1;
        check("reset_state", ALU_result, 64'h0);

        // Reset then first valid result, both signedness modes
        for (int s = 0; s < 2; s++) begin
            @(negedge clock);
            clear = 1'b0;
            drive(32'd2, 32'd3, c_OP_MUL, s[0]);
            @(posedge clock); #1;
            check("clear_holds_zero", ALU_result, 64'h0);
            @(negedge clock);
            clear = 1'b1;
            @(posedge clock); #1;
            check("first_after_clear", ALU_result, 64'h6);
        end

        // Directed vector table
        for (int i = 0; i < c_NVEC; i++) begin
            @(negedge clock);
            drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sf);
            @(posedge clock); #1;
            if (ALU_result !== vecs[i].exp) begin
                n_checks++;
                n_fail++;
                $display("FAIL vec%0d op=%0d: got %h expected %h", i, vecs[i].op, ALU_result, vecs[i].exp);
            end else begin
                n_checks++;
            end
        end

        // Inputs changing between edges must not disturb the registered result
        @(negedge clock);
        drive(32'd10, 32'd20, c_OP_ADD, 1'b0);
        @(posedge clock); #1;
        check("hold_pre", ALU_result, 64'h1E);
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, c_OP_MUL, 1'b0);
        #2;
        check("hold_mid1", ALU_result, 64'h1E);
        @(negedge clock);
        check("hold_mid2", ALU_result, 64'h1E);
        @(posedge clock); #1;
        check("hold_next_edge", ALU_result, 64'hFFFFFFFE_00000001);

        // Mid-stream reset, then recovery on the first edge with clear high
        @(negedge clock);
        clear = 1'b0;
        drive(32'd9, 32'd4, c_OP_SUB, 1'b0);
        @(posedge clock); #1;
        check("midstream_clear", ALU_result, 64'h0);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock); #1;
        check("midstream_recover", ALU_result, 64'h5);
        // Reset has no effect until the edge
        @(negedge clock);
        clear = 1'b0;
        #2;
        check("clear_is_sync", ALU_result, 64'h5);
        @(posedge clock); #1;
        check("clear_at_edge", ALU_result, 64'h0);
        clear = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 clock  input  1  rising-edge clock; all state updates on this edge.
REQ-002 clear  input  1  synchronous active-low reset; sampled on the rising edge of clock.
REQ-003 input_a  input  32  operand A.
REQ-004 input_b  input  32  operand B; bits [4:0] give the shift/rotate amount.
REQ-005 opcode  input  5  operation select, encoded per REQ-009.
REQ-006 unsigned_flag  input  1  0 = unsigned interpretation, 1 = signed (two's complement) interpretation.
REQ-007 ALU_result  output  64  registered result.

Function
REQ-008 The block SHALL compute combinationally from the inputs and register the value into ALU_result on each rising clock edge while clear=1; latency is exactly 1 cycle.
REQ-009 Opcode map SHALL be: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 SHR, 7 SHRA, 8 SHL, 9 ROR, 10 ROL, 11 NEG, 12 NOT; opcodes 13-31 SHALL produce 64'h0.
REQ-010 ADD/SUB SHALL form a 33-bit result in [32:0]; [63:33] are zero-extended when unsigned_flag=0 and sign-extended from bit 32 when unsigned_flag=1 (signed case: bit 32 = true sign of the 33-bit signed sum/difference).
REQ-011 MUL SHALL return the full 64-bit product, unsigned or signed per unsigned_flag.
REQ-012 DIV SHALL place quotient in [31:0] and remainder in [63:32]; signed division truncates toward zero, remainder takes dividend sign.
REQ-013 DIV by zero SHALL return quotient 32'hFFFFFFFF and remainder = input_a.
REQ-014 Signed DIV of 32'h80000000 by 32'hFFFFFFFF SHALL return quotient 32'h80000000, remainder 0.
REQ-015 AND, OR, NOT(input_a), NEG(0 - input_a) SHALL produce a 32-bit value in [31:0] with [63:32]=0; NEG and NOT are unaffected by unsigned_flag.
REQ-016 SHR/SHL SHALL be logical shifts of input_a by input_b[4:0]; SHRA SHALL shift right replicating input_a[31]; ROR/ROL rotate input_a by input_b[4:0]; all produce [63:32]=0; a shift amount of 0 returns input_a.
REQ-017 unsigned_flag SHALL affect only ADD, SUB, MUL and DIV.
REQ-018 Input changes between edges SHALL have no effect on ALU_result until the next rising edge.

Reset
REQ-019 When clear=0 at a rising edge, ALU_result SHALL become 64'h0 regardless of other inputs, including when asserted mid-stream; the first valid result appears on the first edge with clear=1.
REQ-020 No asynchronous path from clear to ALU_result SHALL exist.

Structure
REQ-021 Opcode constants (5-bit localparams for the 13 operations) SHALL live in a shared package alu_pkg, imported by alu_unit and its bench.
REQ-022 Signed/unsigned division SHALL be implemented in one sub-module alu_div (combinational, 32-bit dividend/divisor, signed select, quotient/remainder outputs, divide-by-zero rule of REQ-013/014); all other operations reside in alu_unit.

Verification
REQ-023 clear=0 one edge with input_a=2, input_b=3, opcode=2 -> ALU_result=64'h0; then clear=1 -> 64'h6 after one edge, both unsigned_flag values.
REQ-024 MUL input_a=32'hFFFFFFFE, input_b=3: unsigned_flag=1 -> 64'hFFFFFFFF_FFFFFFFA; unsigned_flag=0 -> 64'h00000002_FFFFFFFA.
REQ-025 ADD input_a=32'hFFFFFFFF, input_b=1: unsigned_flag=0 -> 64'h00000001_00000000; unsigned_flag=1 -> 64'h0.
REQ-026 DIV signed input_a=-7, input_b=2 -> 64'hFFFFFFFF_FFFFFFFD; DIV input_a=5, input_b=0 -> 64'h00000005_FFFFFFFF.
REQ-027 SHRA input_a=32'h80000000, input_b=4 -> 64'h00000000_F8000000; ROL input_a=32'h80000001, input_b=1 -> 64'h00000000_00000003.
REQ-028 opcode=20 any operands -> 64'h0; inputs changed mid-cycle -> output holds until next edge.
